// File: rtl/hazard_forward_unit.sv
// Purpose: EX-stage forwarding selects plus a single pipeline stall covering load-use and multi-cycle unit hazards.
// Latency: fwd_sel/stall are combinational (0 cycles); the scoreboard is registered and tracks one op for MC_LAT cycles.
// Backpressure: none accepted; stall is the backpressure this block applies to the PC, IF/ID and ID/EX stages.
//
// Ports:
//   clk, arst                  clock (rising edge), asynchronous active-high reset
//   rs_id, rs_valid_id         ID-stage source registers (packed, ADDR_W each) and per-source read enables
//   rd_id, reg_write_id        ID-stage destination and write enable
//   mc_op_id                   ID instruction needs the multi-cycle unit
//   rs_ex                      EX-stage source registers, same packing as rs_id
//   rd_id_ex, reg_write_id_ex, mem_read_id_ex, mc_start_id_ex
//                              EX-stage destination, write enable, is-load, launches multi-cycle unit
//   rd_ex_mem, reg_write_ex_mem, rd_mem_wb, reg_write_mem_wb
//                              MEM and WB stage destinations and write enables
//   flush_in                   IF/ID squashed this cycle (suppresses stall only)
//   fwd_sel                    2 bits per EX source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall                      hold PC and IF/ID, bubble into ID/EX
//   mc_busy, mc_rd, mc_done    scoreboard occupied, pending destination, write-back pulse
//   mc_err                     sticky: start received while busy and not on the done cycle
//   stall_cnt                  saturating stall cycle counter
module hazard_forward_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [NUM_SRC*ADDR_W-1:0]   rs_id,
  input  logic [NUM_SRC-1:0]          rs_valid_id,
  input  logic [ADDR_W-1:0]           rd_id,
  input  logic                        reg_write_id,
  input  logic                        mc_op_id,
  input  logic [NUM_SRC*ADDR_W-1:0]   rs_ex,
  input  logic [ADDR_W-1:0]           rd_id_ex,
  input  logic                        reg_write_id_ex,
  input  logic                        mem_read_id_ex,
  input  logic                        mc_start_id_ex,
  input  logic [ADDR_W-1:0]           rd_ex_mem,
  input  logic                        reg_write_ex_mem,
  input  logic [ADDR_W-1:0]           rd_mem_wb,
  input  logic                        reg_write_mem_wb,
  input  logic                        flush_in,
  output logic [2*NUM_SRC-1:0]        fwd_sel,
  output logic                        stall,
  output logic                        mc_busy,
  output logic [ADDR_W-1:0]           mc_rd,
  output logic                        mc_done,
  output logic                        mc_err,
  output logic [15:0]                 stall_cnt
);

  localparam int                CNT_W    = $clog2(MC_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MC_LAT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mc_state_t;

  mc_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  mc_rd_q, mc_rd_d;
  logic               mc_err_q, mc_err_d;
  logic [15:0]        stall_cnt_q;

  logic               busy;
  logic               last_cycle;
  logic               load_use_hit;
  logic               raw_hit;
  logic               load_use_haz;
  logic               raw_haz;
  logic               struct_haz;
  logic               waw_haz;

  // ---------------------------------------------------------------------------
  // Forwarding: EX/MEM is the younger producer, so it is checked first.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [ADDR_W-1:0] ex_src;
    ex_src  = '0;
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_src = rs_ex[i*ADDR_W +: ADDR_W];
      if (ex_src != REG_ZERO) begin
        if (reg_write_ex_mem && (rd_ex_mem == ex_src)) begin
          fwd_sel[2*i +: 2] = 2'b01;
        end else if (reg_write_mem_wb && (rd_mem_wb == ex_src)) begin
          fwd_sel[2*i +: 2] = 2'b10;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ID source matching against the EX load destination and the pending
  // multi-cycle destination. Register 0 and unread sources never match.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [ADDR_W-1:0] id_src;
    id_src       = '0;
    load_use_hit = 1'b0;
    raw_hit      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_src = rs_id[i*ADDR_W +: ADDR_W];
      if (rs_valid_id[i] && (id_src != REG_ZERO)) begin
        if (id_src == rd_id_ex) begin
          load_use_hit = 1'b1;
        end
        if (id_src == mc_rd_q) begin
          raw_hit = 1'b1;
        end
      end
    end
  end

  assign busy       = (state_q == S_BUSY);
  assign last_cycle = busy && (cnt_q == CNT_ONE);

  assign load_use_haz = load_use_hit && mem_read_id_ex && reg_write_id_ex;
  // The multi-cycle result is written back in the done cycle but cannot be
  // forwarded, so a reader still waits through that cycle.
  assign raw_haz      = busy && raw_hit;
  // A new multi-cycle op or a same-destination writer may issue in the done
  // cycle: the unit is free at the next edge and the older write lands first.
  assign struct_haz   = busy && mc_op_id && !last_cycle;
  assign waw_haz      = busy && reg_write_id && (rd_id != REG_ZERO) &&
                        (rd_id == mc_rd_q) && !last_cycle;

  assign stall = (load_use_haz || raw_haz || struct_haz || waw_haz) && !flush_in && !arst;

  // ---------------------------------------------------------------------------
  // Scoreboard FSM for the single non-forwardable multi-cycle unit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_rd_d  = mc_rd_q;
    mc_err_d = mc_err_q;
    case (state_q)
      S_IDLE: begin
        if (mc_start_id_ex) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
          mc_rd_d = rd_id_ex;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          if (mc_start_id_ex) begin
            // Back-to-back: the unit frees up at this edge, so the new op
            // is accepted and the countdown restarts.
            cnt_d   = CNT_LOAD;
            mc_rd_d = rd_id_ex;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          // Start while the unit is occupied: dropped, but flagged for good.
          if (mc_start_id_ex) begin
            mc_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mc_rd_q  <= '0;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mc_rd_q  <= mc_rd_d;
      mc_err_q <= mc_err_d;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign mc_busy   = busy;
  assign mc_rd     = mc_rd_q;
  assign mc_done   = last_cycle;
  assign mc_err    = mc_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Purpose: directed stimulus for hazard_forward_unit with expected values queued per cycle.
// Latency: expectations are tagged with the cycle they apply to and checked at the following falling edge.
// Backpressure: none; the checker drains every expectation whose cycle has arrived.
module tb_hazard_forward_unit;

  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 2;
  localparam int MC_LAT  = 4;

  localparam logic [2:0] K_FWD   = 3'd0;
  localparam logic [2:0] K_STALL = 3'd1;
  localparam logic [2:0] K_BUSY  = 3'd2;
  localparam logic [2:0] K_RD    = 3'd3;
  localparam logic [2:0] K_DONE  = 3'd4;
  localparam logic [2:0] K_ERR   = 3'd5;
  localparam logic [2:0] K_CNT   = 3'd6;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  kind;
    logic [31:0] val;
  } exp_t;

  logic                       clk;
  logic                       arst;
  logic [NUM_SRC*ADDR_W-1:0]  rs_id;
  logic [NUM_SRC-1:0]         rs_valid_id;
  logic [ADDR_W-1:0]          rd_id;
  logic                       reg_write_id;
  logic                       mc_op_id;
  logic [NUM_SRC*ADDR_W-1:0]  rs_ex;
  logic [ADDR_W-1:0]          rd_id_ex;
  logic                       reg_write_id_ex;
  logic                       mem_read_id_ex;
  logic                       mc_start_id_ex;
  logic [ADDR_W-1:0]          rd_ex_mem;
  logic                       reg_write_ex_mem;
  logic [ADDR_W-1:0]          rd_mem_wb;
  logic                       reg_write_mem_wb;
  logic                       flush_in;
  logic [2*NUM_SRC-1:0]       fwd_sel;
  logic                       stall;
  logic                       mc_busy;
  logic [ADDR_W-1:0]          mc_rd;
  logic                       mc_done;
  logic                       mc_err;
  logic [15:0]                stall_cnt;

  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] mon_act;

  hazard_forward_unit #(
    .ADDR_W (ADDR_W),
    .NUM_SRC(NUM_SRC),
    .MC_LAT (MC_LAT)
  ) dut (
    .clk             (clk),
    .arst            (arst),
    .rs_id           (rs_id),
    .rs_valid_id     (rs_valid_id),
    .rd_id           (rd_id),
    .reg_write_id    (reg_write_id),
    .mc_op_id        (mc_op_id),
    .rs_ex           (rs_ex),
    .rd_id_ex        (rd_id_ex),
    .reg_write_id_ex (reg_write_id_ex),
    .mem_read_id_ex  (mem_read_id_ex),
    .mc_start_id_ex  (mc_start_id_ex),
    .rd_ex_mem       (rd_ex_mem),
    .reg_write_ex_mem(reg_write_ex_mem),
    .rd_mem_wb       (rd_mem_wb),
    .reg_write_mem_wb(reg_write_mem_wb),
    .flush_in        (flush_in),
    .fwd_sel         (fwd_sel),
    .stall           (stall),
    .mc_busy         (mc_busy),
    .mc_rd           (mc_rd),
    .mc_done         (mc_done),
    .mc_err          (mc_err),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input logic [2:0] k);
    case (k)
      K_FWD:   return "fwd_sel";
      K_STALL: return "stall";
      K_BUSY:  return "mc_busy";
      K_RD:    return "mc_rd";
      K_DONE:  return "mc_done";
      K_ERR:   return "mc_err";
      K_CNT:   return "stall_cnt";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] get_out(input logic [2:0] k);
    case (k)
      K_FWD:   return 32'(fwd_sel);
      K_STALL: return 32'(stall);
      K_BUSY:  return 32'(mc_busy);
      K_RD:    return 32'(mc_rd);
      K_DONE:  return 32'(mc_done);
      K_ERR:   return 32'(mc_err);
      K_CNT:   return 32'(stall_cnt);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Checker: drains every expectation due in the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= 32'(cyc)) begin
      mon_e   = exp_q.pop_front();
      mon_act = get_out(mon_e.kind);
      checks  = checks + 1;
      if (mon_e.cyc != 32'(cyc) || mon_act !== mon_e.val) begin
        errors = errors + 1;
        $display("FAIL %s cycle=%0d got=%0h expected=%0h (checked at cycle %0d)",
                 kind_name(mon_e.kind), mon_e.cyc, mon_act, mon_e.val, cyc);
      end
    end
  end

  task automatic expect_out(input logic [2:0] kind, input logic [31:0] val);
    exp_t e;
    e.cyc  = 32'(cyc);
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs_id            = '0;
    rs_valid_id      = '0;
    rd_id            = '0;
    reg_write_id     = 1'b0;
    mc_op_id         = 1'b0;
    rs_ex            = '0;
    rd_id_ex         = '0;
    reg_write_id_ex  = 1'b0;
    mem_read_id_ex   = 1'b0;
    mc_start_id_ex   = 1'b0;
    rd_ex_mem        = '0;
    reg_write_ex_mem = 1'b0;
    rd_mem_wb        = '0;
    reg_write_mem_wb = 1'b0;
    flush_in         = 1'b0;
  endtask

  task automatic set_rs_id(input int i, input logic [ADDR_W-1:0] v);
    rs_id[i*ADDR_W +: ADDR_W] = v;
  endtask

  task automatic set_rs_ex(input int i, input logic [ADDR_W-1:0] v);
    rs_ex[i*ADDR_W +: ADDR_W] = v;
  endtask

  task automatic load_use_hazard();
    mem_read_id_ex  = 1'b1;
    reg_write_id_ex = 1'b1;
    rd_id_ex        = 5'd7;
    set_rs_id(1, 5'd7);
    rs_valid_id     = 2'b10;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    arst = 1'b1;
    tick();
    tick();

    // Reset state; a hazard during reset must not stall.
    load_use_hazard();
    expect_out(K_STALL, 0);
    expect_out(K_BUSY, 0);
    expect_out(K_RD, 0);
    expect_out(K_DONE, 0);
    expect_out(K_ERR, 0);
    expect_out(K_CNT, 0);
    tick();
    clr();
    arst = 1'b0;
    tick();
    expect_out(K_CNT, 0);

    // Forwarding priority.
    tick(); clr();
    set_rs_ex(0, 5'd5); rd_ex_mem = 5'd5; rd_mem_wb = 5'd5;
    reg_write_ex_mem = 1'b1; reg_write_mem_wb = 1'b1;
    expect_out(K_FWD, 32'b0001);
    #1;
    checks = checks + 1;
    if (fwd_sel !== 4'b0001) begin
      errors = errors + 1;
      $display("FAIL fwd_sel direct got=%0b expected=0001", fwd_sel);
    end
    tick();
    reg_write_ex_mem = 1'b0;
    expect_out(K_FWD, 32'b0010);
    tick();
    set_rs_ex(1, 5'd5);
    expect_out(K_FWD, 32'b1010);
    tick(); clr();
    reg_write_ex_mem = 1'b1; reg_write_mem_wb = 1'b1;
    expect_out(K_FWD, 32'b0000);
    tick(); clr();
    set_rs_ex(0, 5'd6); set_rs_ex(1, 5'd3);
    rd_ex_mem = 5'd3; rd_mem_wb = 5'd6;
    reg_write_ex_mem = 1'b1; reg_write_mem_wb = 1'b1;
    expect_out(K_FWD, 32'b0110);
    expect_out(K_STALL, 0);

    // Load-use: one stall cycle, then the bubble has replaced the load.
    tick(); clr();
    load_use_hazard();
    expect_out(K_STALL, 1);
    expect_out(K_CNT, 0);
    #1;
    checks = checks + 1;
    if (stall !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL stall direct (load-use) got=%0b expected=1", stall);
    end
    tick(); clr();
    expect_out(K_STALL, 0);
    expect_out(K_CNT, 1);
    tick(); clr();
    load_use_hazard();
    rs_valid_id = 2'b01;
    expect_out(K_STALL, 0);
    tick(); clr();
    load_use_hazard();
    flush_in = 1'b1;
    expect_out(K_STALL, 0);
    #1;
    checks = checks + 1;
    if (stall !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL stall direct (flush) got=%0b expected=0", stall);
    end
    tick(); clr();
    expect_out(K_CNT, 1);

    // Scoreboard RAW: start rd=9, reader of r9 held from T+1.
    tick(); clr();
    mc_start_id_ex = 1'b1; rd_id_ex = 5'd9;
    expect_out(K_BUSY, 0);
    for (int k = 1; k <= MC_LAT; k++) begin
      tick(); clr();
      set_rs_id(0, 5'd9); rs_valid_id = 2'b01;
      expect_out(K_BUSY, 1);
      expect_out(K_RD, 9);
      expect_out(K_DONE, 32'(k == MC_LAT));
      expect_out(K_STALL, 1);
    end
    tick(); clr();
    set_rs_id(0, 5'd9); rs_valid_id = 2'b01;
    expect_out(K_BUSY, 0);
    expect_out(K_DONE, 0);
    expect_out(K_STALL, 0);
    expect_out(K_CNT, 5);

    // Structural hazard, then a start on the done cycle.
    tick(); clr();
    mc_start_id_ex = 1'b1; rd_id_ex = 5'd12;
    for (int k = 1; k <= MC_LAT; k++) begin
      tick(); clr();
      mc_op_id = 1'b1;
      expect_out(K_RD, 12);
      expect_out(K_STALL, 32'(k != MC_LAT));
      expect_out(K_DONE, 32'(k == MC_LAT));
      if (k == MC_LAT) begin
        mc_start_id_ex = 1'b1;
        rd_id_ex       = 5'd14;
      end
    end
    tick(); clr();
    reg_write_id = 1'b1; rd_id = 5'd14;
    expect_out(K_BUSY, 1);
    expect_out(K_RD, 14);
    expect_out(K_DONE, 0);
    expect_out(K_STALL, 1);
    tick(); clr();
    reg_write_id = 1'b1; rd_id = 5'd15;
    expect_out(K_STALL, 0);
    tick(); clr();
    expect_out(K_DONE, 0);
    tick(); clr();
    reg_write_id = 1'b1; rd_id = 5'd14;
    expect_out(K_DONE, 1);
    expect_out(K_STALL, 0);
    tick(); clr();
    expect_out(K_BUSY, 0);
    expect_out(K_CNT, 9);
    expect_out(K_ERR, 0);

    // Start while busy: flagged, ignored, original done unaffected.
    tick(); clr();
    mc_start_id_ex = 1'b1; rd_id_ex = 5'd20;
    tick(); clr();
    expect_out(K_ERR, 0);
    tick(); clr();
    mc_start_id_ex = 1'b1; rd_id_ex = 5'd21;
    expect_out(K_ERR, 0);
    tick(); clr();
    expect_out(K_ERR, 1);
    expect_out(K_RD, 20);
    expect_out(K_BUSY, 1);
    expect_out(K_DONE, 0);
    tick(); clr();
    expect_out(K_DONE, 1);
    expect_out(K_RD, 20);
    tick(); clr();
    expect_out(K_BUSY, 0);
    expect_out(K_ERR, 1);

    // Reset in the middle of a BUSY period.
    tick(); clr();
    mc_start_id_ex = 1'b1; rd_id_ex = 5'd22;
    tick(); clr();
    set_rs_id(0, 5'd22); rs_valid_id = 2'b01;
    expect_out(K_BUSY, 1);
    expect_out(K_STALL, 1);
    tick(); clr();
    set_rs_id(0, 5'd22); rs_valid_id = 2'b01;
    arst = 1'b1;
    expect_out(K_BUSY, 0);
    expect_out(K_DONE, 0);
    expect_out(K_STALL, 0);
    expect_out(K_CNT, 0);
    expect_out(K_ERR, 0);
    expect_out(K_RD, 0);
    tick(); clr();
    arst = 1'b0;
    expect_out(K_BUSY, 0);
    tick(); clr();
    expect_out(K_DONE, 0);
    tick(); clr();
    expect_out(K_DONE, 0);
    expect_out(K_CNT, 0);

    // Saturation of the stall counter under a permanently held hazard.
    tick(); clr();
    load_use_hazard();
    expect_out(K_STALL, 1);
    expect_out(K_CNT, 0);
    for (int k = 1; k <= 70000; k++) begin
      tick();
      if (k == 100)   expect_out(K_CNT, 100);
      if (k == 65534) expect_out(K_CNT, 32'hFFFE);
      if (k == 65535) expect_out(K_CNT, 32'hFFFF);
      if (k == 70000) expect_out(K_CNT, 32'hFFFF);
    end
    tick(); clr();
    expect_out(K_STALL, 0);
    expect_out(K_CNT, 32'hFFFF);

    tick();
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s cycle=%0d never checked, expected=%0h",
               kind_name(mon_e.kind), mon_e.cyc, mon_e.val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
